// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down modulo counter with load, wrap/saturate and wrap pulses; UPDOWN_DIV_TOGGLE_EN adds div_out
module updown_counter_mod #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             incr,
  input  logic             decr,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             at_max,
  output logic             at_min
`ifdef UPDOWN_DIV_TOGGLE_EN
  ,
  output logic             div_out
`endif
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic up, dn, wu_n, wd_n;
  logic [WIDTH-1:0] count_n;
  assign at_max = count == MAX;
  assign at_min = count == '0;
  assign up = en & incr & ~decr & ~load;
  assign dn = en & decr & ~incr & ~load;
  // next count and wrap detection; load clamps, steps wrap or saturate at the bounds
  always_comb begin
    wu_n = up & ~sat_mode & at_max;
    wd_n = dn & ~sat_mode & at_min;
    count_n = load ? (load_val > MAX ? MAX : load_val) :
              up   ? (at_max ? (sat_mode ? count : '0) : count + 1'b1) :
              dn   ? (at_min ? (sat_mode ? count : MAX) : count - 1'b1) : count;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
    end else begin
      count <= count_n;
      wrap_up <= wu_n;
      wrap_dn <= wd_n;
    end
  end
`ifdef UPDOWN_DIV_TOGGLE_EN
  // divided strobe flips on every wrap in either direction
  always_ff @(posedge clk) begin
    if (rst) div_out <= 1'b0;
    else if (wu_n | wd_n) div_out <= ~div_out;
  end
`endif
endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down modulo counter. It is the next generation of the team's 4-bit incr/decr counter, generalised in width and terminal value. It adds parallel load, a runtime wrap/saturate mode, and terminal-count pulses, and serves as the core of the frequency-divider and event-counting blocks.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MAX_VAL, (1<<WIDTH)-1, terminal count value; legal range 1..2^WIDTH-1; the count range is 0..MAX_VAL

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; gates incr/decr only
incr  input  1  step up request
decr  input  1  step down request
sat_mode  input  1  1 = saturate at the bounds, 0 = wrap modulo MAX_VAL+1
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
count  output  WIDTH  current count (registered)
wrap_up  output  1  one-cycle pulse: the count wrapped from MAX_VAL to 0
wrap_dn  output  1  one-cycle pulse: the count wrapped from 0 to MAX_VAL
at_max  output  1  count == MAX_VAL (combinational decode of the count register)
at_min  output  1  count == 0 (combinational decode of the count register)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: count=0, wrap_up=0, wrap_dn=0, and div_out=0 when the optional feature is present. This gives at_min=1 and at_max=0.
- Priority per edge: rst > load > step > hold.
- Reset mid-operation: rst dominates every other input in the same cycle. A pending wrap pulse is cleared on the following edge.
- load=1:
  - count <= load_val if load_val <= MAX_VAL; otherwise count <= MAX_VAL (clamp).
  - Load is independent of en and sat_mode.
  - No wrap pulse is generated.
- Step, when en=1 and load=0:
  - incr=1, decr=0: step up.
  - incr=0, decr=1: step down.
  - incr=1, decr=1: hold. This is deliberate; there is no incr priority.
  - incr=0, decr=0: hold.
- Step up when count < MAX_VAL: count+1.
- Step up when count == MAX_VAL:
  - sat_mode=0: count <= 0 and wrap_up=1 on the next cycle.
  - sat_mode=1: count holds, no pulse.
- Step down when count > 0: count-1.
- Step down when count == 0:
  - sat_mode=0: count <= MAX_VAL and wrap_dn=1.
  - sat_mode=1: count holds, no pulse.
- en=0: count holds unless load. wrap_up and wrap_dn are 0.
- Pulse timing: wrap_up and wrap_dn are registered. Each is high for exactly the one cycle in which count first shows the wrapped value. In any cycle that is not itself a wrap, both are 0.
- Latency: every count change appears one clk edge after the qualifying inputs are sampled.
- Arithmetic:
  - Next-state compare is done at WIDTH bits against MAX_VAL, with no reliance on natural 2^WIDTH overflow.
  - MAX_VAL < 2^WIDTH-1 must still wrap at MAX_VAL.
- sat_mode may change on any cycle. It takes effect on the very next step.

Optional Feature:
Macro: UPDOWN_DIV_TOGGLE_EN.
- When defined:
  - Adds output div_out (1 bit, reset 0).
  - div_out toggles on every edge at which wrap_up or wrap_dn is set.
  - With incr held high, en=1, sat_mode=0, div_out has period 2*(MAX_VAL+1) clk cycles at 50% duty. This gives a divide-by-2(MAX_VAL+1) clock enable/strobe.
  - load does not change div_out.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=4, MAX_VAL=9. rst=1 for 2 cycles, then rst=0, en=1, incr=1 for 10 cycles.
   -> count 0..9, then 0. wrap_up is high only in the cycle count returns to 0. at_max is high while count=9.
2. MAX_VAL=9, count=0, sat_mode=0, decr=1 for 1 cycle.
   -> count=9, wrap_dn=1 for 1 cycle.
   Then sat_mode=1 with decr from 0.
   -> count stays 0, wrap_dn=0.
3. Saturate up: count=9, sat_mode=1, incr=1 for 5 cycles.
   -> count stays 9, wrap_up stays 0, at_max=1 throughout.
4. load=1 with load_val=4'd6 and incr=1 in the same cycle -> count=6 (load wins).
   load_val=4'd14 -> count=9 (clamp).
   load with en=0 -> still loads.
5. count=5, incr=1 and decr=1 together -> count holds at 5.
   rst=1 asserted at the same edge as a wrap condition at count=9 -> count=0, wrap_up=0.
6. With UPDOWN_DIV_TOGGLE_EN defined, MAX_VAL=3, incr held high for 16 cycles.
   -> div_out toggles every 4 cycles (period 8). Undefined build compiles without div_out.
